pe_sequencer: RTL and testbench

PE_SEQUENCER -- requirements
Module: pe_sequencer

---
 rtl/pe_pkg.sv | 30 +++
 rtl/pe_sequencer_if.sv | 28 ++
 rtl/pe_sum_accum.sv | 48 ++++
 rtl/pe_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pe_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared state encoding, default sizing and the ceil-log2 helper for the
// pe sequencer and its accumulators.
package pe_pkg;

    localparam int DEF_NUM_PE     = 2;
    localparam int DEF_PIX_PER_PE = 2;
    localparam int DEF_SUM_W      = 16;
    localparam int DEF_TIMEOUT    = 1023;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SUM_START,
        ST_SUM_WAIT,
        ST_ACCUM,
        ST_BG_START,
        ST_BG_WAIT,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_sequencer_if.sv
// Sequencer <-> pe array bundle. The master raises a start bit for one cycle;
// each pe answers with a done flag (level or pulse, held sticky by the master);
// ack is a one-cycle pulse telling every pe to return to its initial state.
interface pe_sequencer_if
    import pe_pkg::*;
#(
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int SUM_W  = DEF_SUM_W
);
    logic [NUM_PE-1:0]       start_sum;
    logic [NUM_PE-1:0]       start_bg;
    logic                    ack;
    logic [NUM_PE-1:0]       qsd;
    logic [NUM_PE-1:0]       qbgd;
    logic [NUM_PE*SUM_W-1:0] red_sum;
    logic [NUM_PE*SUM_W-1:0] green_sum;
    logic [NUM_PE*SUM_W-1:0] blue_sum;

    modport master (
        output start_sum, start_bg, ack,
        input  qsd, qbgd, red_sum, green_sum, blue_sum
    );

    modport slave (
        input  start_sum, start_bg, ack,
        output qsd, qbgd, red_sum, green_sum, blue_sum
    );
endinterface

// File: rtl/pe_sum_accum.sv
// One colour channel: serially accumulates per-pe sums, then divides by the
// pixel count with a right shift and saturates the result to 8 bits.
module pe_sum_accum
    import pe_pkg::*;
#(
    parameter int SUM_W = DEF_SUM_W,
    parameter int ACC_W = DEF_SUM_W + 1,
    parameter int SHIFT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic             last_i,
    input  logic [SUM_W-1:0] sum_i,
    output logic [7:0]       exp_o
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] total;
    logic [ACC_W-1:0] shifted;
    logic [7:0]       exp_q, exp_d;

    // The average is captured on the final add so it is valid the next cycle.
    always_comb begin
        total   = acc_q + ACC_W'(sum_i);
        shifted = total >> SHIFT;
        acc_d   = acc_q;
        exp_d   = exp_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = total;
            if (last_i) exp_d = (shifted > ACC_W'(255)) ? 8'hFF : shifted[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            exp_q <= '0;
        end else begin
            acc_q <= acc_d;
            exp_q <= exp_d;
        end
    end

    assign exp_o = exp_q;
endmodule

// File: rtl/pe_sequencer.sv
// Frame sequencer for an array of pe: sum phase, channel averaging, then
// background-removal phase, with per-phase timeout and host Done/Error handshake.
module pe_sequencer
    import pe_pkg::*;
#(
    parameter int NUM_PE     = DEF_NUM_PE,
    parameter int PIX_PER_PE = DEF_PIX_PER_PE,
    parameter int SUM_W      = DEF_SUM_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic                    Ack,
    input  logic [7:0]              threshold_in,
    input  logic [7:0]              bg_r_in,
    input  logic [7:0]              bg_g_in,
    input  logic [7:0]              bg_b_in,
    input  logic [NUM_PE-1:0]       pe_Qsd,
    input  logic [NUM_PE-1:0]       pe_Qbgd,
    input  logic [NUM_PE*SUM_W-1:0] pe_red_sum,
    input  logic [NUM_PE*SUM_W-1:0] pe_green_sum,
    input  logic [NUM_PE*SUM_W-1:0] pe_blue_sum,
    output logic [NUM_PE-1:0]       pe_Start_Sum,
    output logic [NUM_PE-1:0]       pe_Start_BgRemoval,
    output logic                    pe_Ack,
    output logic [7:0]              red_exp,
    output logic [7:0]              green_exp,
    output logic [7:0]              blue_exp,
    output logic [7:0]              threshold,
    output logic [7:0]              desired_bg_r,
    output logic [7:0]              desired_bg_g,
    output logic [7:0]              desired_bg_b,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error,
    output logic                    Qi,
    output logic                    Qss,
    output logic                    Qsw,
    output logic                    Qacc,
    output logic                    Qbs,
    output logic                    Qbw,
    output logic                    Qd,
    output logic                    Qe
);
    // NUM_PE*PIX_PER_PE must be a power of two: the average is a plain shift.
    localparam int SHIFT = clog2(NUM_PE * PIX_PER_PE);
    localparam int ACC_W = SUM_W + clog2(NUM_PE);
    localparam int IDX_W = (NUM_PE > 1) ? clog2(NUM_PE) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic [NUM_PE-1:0] flags_q, flags_d;
    logic [NUM_PE-1:0] merged;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ack_q, ack_d;
    logic [7:0]        thr_q, thr_d, bgr_q, bgr_d, bgg_q, bgg_d, bgb_q, bgb_d;
    logic              acc_clr, acc_add, acc_last;

    assign merged = flags_q | ((state_q == ST_SUM_WAIT) ? pe_Qsd : pe_Qbgd);

    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ack_d    = 1'b0;
        thr_d    = thr_q;
        bgr_d    = bgr_q;
        bgg_d    = bgg_q;
        bgb_d    = bgb_q;
        acc_clr  = 1'b0;
        acc_add  = 1'b0;
        acc_last = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (Start) begin
                    thr_d   = threshold_in;
                    bgr_d   = bg_r_in;
                    bgg_d   = bg_g_in;
                    bgb_d   = bg_b_in;
                    acc_clr = 1'b1;
                    state_d = ST_SUM_START;
                end
            end
            ST_SUM_START, ST_BG_START: begin
                flags_d = '0;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = (state_q == ST_SUM_START) ? ST_SUM_WAIT : ST_BG_WAIT;
            end
            ST_SUM_WAIT, ST_BG_WAIT: begin
                flags_d = merged;
                // Completion is checked before expiry so a last-cycle flag still wins.
                if (&merged) begin
                    ack_d   = 1'b1;
                    state_d = (state_q == ST_SUM_WAIT) ? ST_ACCUM : ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACCUM: begin
                acc_add  = 1'b1;
                acc_last = (idx_q == IDX_W'(NUM_PE - 1));
                if (acc_last) state_d = ST_BG_START;
                else          idx_d   = idx_q + IDX_W'(1);
            end
            ST_DONE: begin
                if (Ack) state_d = ST_INIT;
            end
            ST_ERR: begin
                if (Ack) begin
                    ack_d   = 1'b1;
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_INIT;
            flags_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            thr_q   <= '0;
            bgr_q   <= '0;
            bgg_q   <= '0;
            bgb_q   <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            thr_q   <= thr_d;
            bgr_q   <= bgr_d;
            bgg_q   <= bgg_d;
            bgb_q   <= bgb_d;
        end
    end

    pe_sum_accum #(.SUM_W(SUM_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_red (
        .clk_i(Clk), .rst_i(Reset), .clr_i(acc_clr), .add_i(acc_add), .last_i(acc_last),
        .sum_i(pe_red_sum[int'(idx_q) * SUM_W +: SUM_W]), .exp_o(red_exp)
    );
    pe_sum_accum #(.SUM_W(SUM_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_green (
        .clk_i(Clk), .rst_i(Reset), .clr_i(acc_clr), .add_i(acc_add), .last_i(acc_last),
        .sum_i(pe_green_sum[int'(idx_q) * SUM_W +: SUM_W]), .exp_o(green_exp)
    );
    pe_sum_accum #(.SUM_W(SUM_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_blue (
        .clk_i(Clk), .rst_i(Reset), .clr_i(acc_clr), .add_i(acc_add), .last_i(acc_last),
        .sum_i(pe_blue_sum[int'(idx_q) * SUM_W +: SUM_W]), .exp_o(blue_exp)
    );

    assign pe_Start_Sum       = {NUM_PE{state_q == ST_SUM_START}};
    assign pe_Start_BgRemoval = {NUM_PE{state_q == ST_BG_START}};
    assign pe_Ack             = ack_q;
    assign threshold          = thr_q;
    assign desired_bg_r       = bgr_q;
    assign desired_bg_g       = bgg_q;
    assign desired_bg_b       = bgb_q;

    assign Qi   = (state_q == ST_INIT);
    assign Qss  = (state_q == ST_SUM_START);
    assign Qsw  = (state_q == ST_SUM_WAIT);
    assign Qacc = (state_q == ST_ACCUM);
    assign Qbs  = (state_q == ST_BG_START);
    assign Qbw  = (state_q == ST_BG_WAIT);
    assign Qd   = (state_q == ST_DONE);
    assign Qe   = (state_q == ST_ERR);

    assign Busy  = !(Qi || Qd || Qe);
    assign Done  = Qd;
    assign Error = Qe;
endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: a default-timeout instance runs full frames, a
// TIMEOUT=15 instance exercises expiry and the success-wins boundary.
module tb_pe_sequencer;
    import pe_pkg::*;

    localparam int NP = 2;
    localparam int SW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, ack, start_t, ack_t;
    logic [7:0] thr_in, bgr_in, bgg_in, bgb_in;

    pe_sequencer_if #(.NUM_PE(NP), .SUM_W(SW)) pif ();
    pe_sequencer_if #(.NUM_PE(NP), .SUM_W(SW)) pif_t ();

    logic [7:0] red_exp, green_exp, blue_exp, threshold, dbg_r, dbg_g, dbg_b;
    logic       busy, done, error, qi, qss, qsw, qacc, qbs, qbw, qd, qe;
    logic [7:0] red_exp_t, green_exp_t, blue_exp_t, threshold_t, dbg_r_t, dbg_g_t, dbg_b_t;
    logic       busy_t, done_t, error_t, qi_t, qss_t, qsw_t, qacc_t, qbs_t, qbw_t, qd_t, qe_t;

    pe_sequencer #(.NUM_PE(NP), .PIX_PER_PE(2), .SUM_W(SW)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .Ack(ack),
        .threshold_in(thr_in), .bg_r_in(bgr_in), .bg_g_in(bgg_in), .bg_b_in(bgb_in),
        .pe_Qsd(pif.qsd), .pe_Qbgd(pif.qbgd),
        .pe_red_sum(pif.red_sum), .pe_green_sum(pif.green_sum), .pe_blue_sum(pif.blue_sum),
        .pe_Start_Sum(pif.start_sum), .pe_Start_BgRemoval(pif.start_bg), .pe_Ack(pif.ack),
        .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp), .threshold(threshold),
        .desired_bg_r(dbg_r), .desired_bg_g(dbg_g), .desired_bg_b(dbg_b),
        .Busy(busy), .Done(done), .Error(error),
        .Qi(qi), .Qss(qss), .Qsw(qsw), .Qacc(qacc), .Qbs(qbs), .Qbw(qbw), .Qd(qd), .Qe(qe)
    );

    pe_sequencer #(.NUM_PE(NP), .PIX_PER_PE(2), .SUM_W(SW), .TIMEOUT(15)) dut_t (
        .Clk(clk), .Reset(rst), .Start(start_t), .Ack(ack_t),
        .threshold_in(thr_in), .bg_r_in(bgr_in), .bg_g_in(bgg_in), .bg_b_in(bgb_in),
        .pe_Qsd(pif_t.qsd), .pe_Qbgd(pif_t.qbgd),
        .pe_red_sum(pif_t.red_sum), .pe_green_sum(pif_t.green_sum), .pe_blue_sum(pif_t.blue_sum),
        .pe_Start_Sum(pif_t.start_sum), .pe_Start_BgRemoval(pif_t.start_bg), .pe_Ack(pif_t.ack),
        .red_exp(red_exp_t), .green_exp(green_exp_t), .blue_exp(blue_exp_t), .threshold(threshold_t),
        .desired_bg_r(dbg_r_t), .desired_bg_g(dbg_g_t), .desired_bg_b(dbg_b_t),
        .Busy(busy_t), .Done(done_t), .Error(error_t),
        .Qi(qi_t), .Qss(qss_t), .Qsw(qsw_t), .Qacc(qacc_t), .Qbs(qbs_t), .Qbw(qbw_t), .Qd(qd_t), .Qe(qe_t)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] avg_sat(input int a, input int b);
        int t;
        t = (a + b) / 4;
        if (t > 255) t = 255;
        return t[7:0];
    endfunction

    task automatic set_sums(input int r0, input int r1, input int g0, input int g1,
                            input int b0, input int b1);
        pif.red_sum   = {r1[15:0], r0[15:0]};
        pif.green_sum = {g1[15:0], g0[15:0]};
        pif.blue_sum  = {b1[15:0], b0[15:0]};
    endtask

    // Runs one full frame on dut; d0/d1 are the SUM_WAIT cycles where each pe
    // pulses its sum-done flag. With poke set, Start and threshold_in are
    // disturbed during BG_WAIT.
    task automatic run_frame(input int d0, input int d1, input bit poke);
        logic [23:0] want;
        logic [31:0] cfg_want;
        int          dmax, pulses;
        dmax     = (d0 > d1) ? d0 : d1;
        pulses   = 0;
        cfg_want = {thr_in, bgr_in, bgg_in, bgb_in};
        exp_q.push_back({avg_sat(int'(pif.red_sum[15:0]), int'(pif.red_sum[31:16])),
                         avg_sat(int'(pif.green_sum[15:0]), int'(pif.green_sum[31:16])),
                         avg_sat(int'(pif.blue_sum[15:0]), int'(pif.blue_sum[31:16]))});
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({qss, busy, pif.start_sum} !== 4'b1111) begin
            n_err++;
            $display("FAIL sum_start: got qss/busy/start=%b want 1111", {qss, busy, pif.start_sum});
        end
        tick();
        for (int c = 0; c <= dmax + 1; c++) begin
            pif.qsd = {c == d1, c == d0};
            tick();
            if (pif.ack === 1'b1) pulses++;
            n_cmp++;
            if (pif.ack !== (c == dmax)) begin
                n_err++;
                $display("FAIL sum_ack_timing: wait cycle %0d got pe_Ack=%b want %b", c + 1, pif.ack, c == dmax);
            end
        end
        pif.qsd = '0;
        n_cmp++;
        if (pulses != 1 || qacc !== 1'b1) begin
            n_err++;
            $display("FAIL sum_done: got %0d ack pulses qacc=%b want 1 pulse qacc=1", pulses, qacc);
        end
        tick();
        n_cmp++;
        if ({qbs, pif.start_bg} !== 3'b111) begin
            n_err++;
            $display("FAIL bg_start: got qbs/start_bg=%b want 111", {qbs, pif.start_bg});
        end
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: got empty queue want one entry");
        end else begin
            want = exp_q.pop_front();
            n_cmp++;
            if ({red_exp, green_exp, blue_exp} !== want) begin
                n_err++;
                $display("FAIL exp_at_bg_start: got %h want %h", {red_exp, green_exp, blue_exp}, want);
            end
        end
        n_cmp++;
        if ({threshold, dbg_r, dbg_g, dbg_b} !== cfg_want) begin
            n_err++;
            $display("FAIL config: got %h want %h", {threshold, dbg_r, dbg_g, dbg_b}, cfg_want);
        end
        tick();
        if (poke) begin
            start  = 1'b1;
            thr_in = ~thr_in;
            for (int c = 0; c < 3; c++) tick();
            start = 1'b0;
            n_cmp++;
            if (qbw !== 1'b1 || threshold !== cfg_want[31:24]) begin
                n_err++;
                $display("FAIL start_ignored: got qbw=%b thr=%h want qbw=1 thr=%h", qbw, threshold, cfg_want[31:24]);
            end
        end
        pif.qbgd = 2'b01;
        tick();
        pif.qbgd = 2'b10;
        tick();
        pif.qbgd = '0;
        n_cmp++;
        if ({qd, done, pif.ack, busy} !== 4'b1110) begin
            n_err++;
            $display("FAIL bg_done: got qd/done/ack/busy=%b want 1110", {qd, done, pif.ack, busy});
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++;
        if ({qi, pif.ack, threshold, dbg_r, dbg_g, dbg_b} !== {2'b10, cfg_want}) begin
            n_err++;
            $display("FAIL done_exit: got %h want %h", {qi, pif.ack, threshold, dbg_r, dbg_g, dbg_b}, {2'b10, cfg_want});
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b1;
        ack     = 1'b1;
        start_t = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({qi, qss, qsw, qacc, qbs, qbw, qd, qe, busy, done, error} !== 11'b10000000000) begin
            n_err++;
            $display("FAIL reset_state: got %b want 10000000000", {qi, qss, qsw, qacc, qbs, qbw, qd, qe, busy, done, error});
        end
        n_cmp++;
        if ({red_exp, green_exp, blue_exp, threshold, dbg_r, dbg_g, dbg_b, pif.ack, pif.start_sum, pif.start_bg} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {red_exp, green_exp, blue_exp, threshold, dbg_r, dbg_g, dbg_b, pif.ack});
        end
        start   = 1'b0;
        ack     = 1'b0;
        start_t = 1'b0;
        rst     = 1'b0;
        tick();
        n_cmp++;
        if (qi !== 1'b1 || qi_t !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got qi=%b qi_t=%b want 1 1", qi, qi_t);
        end
    endtask

    task automatic test_basic();
        set_sums(122, 265, 266, 133, 396, 198);
        thr_in = 8'h5A; bgr_in = 8'h11; bgg_in = 8'h22; bgb_in = 8'h33;
        run_frame(3, 40, 1'b0);
    endtask

    task automatic test_saturate();
        set_sums(1020, 1020, 0, 3, 1023, 1024);
        thr_in = 8'hC3;
        run_frame(0, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        set_sums(7, 9, 100, 200, 300, 400);
        thr_in = 8'h40;
        run_frame(1, 2, 1'b1);
    endtask

    task automatic test_timeout();
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        tick();
        for (int c = 0; c <= 15; c++) begin
            pif_t.qsd = {c == 0, c == 15};
            tick();
            n_cmp++;
            if (pif_t.ack !== (c == 15)) begin
                n_err++;
                $display("FAIL success_wins_ack: cycle %0d got %b want %b", c + 1, pif_t.ack, c == 15);
            end
        end
        pif_t.qsd = '0;
        n_cmp++;
        if (qacc_t !== 1'b1 || qe_t !== 1'b0) begin
            n_err++;
            $display("FAIL success_wins_state: got qacc=%b qe=%b want 1 0", qacc_t, qe_t);
        end
        for (int i = 0; i < 20 && qbw_t !== 1'b1; i++) tick();
        n_cmp++;
        if (qbw_t !== 1'b1) begin
            n_err++;
            $display("FAIL bg_wait_entry: got qbw=%b want 1", qbw_t);
        end
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_cmp++;
            if (qbw_t !== 1'b1 || pif_t.ack !== 1'b0) begin
                n_err++;
                $display("FAIL bg_wait_hold: cycle %0d got qbw=%b ack=%b want 1 0", i, qbw_t, pif_t.ack);
            end
        end
        tick();
        n_cmp++;
        if ({qe_t, error_t, busy_t, pif_t.ack} !== 4'b1100) begin
            n_err++;
            $display("FAIL timeout_err: got qe/err/busy/ack=%b want 1100", {qe_t, error_t, busy_t, pif_t.ack});
        end
        ack_t = 1'b1;
        tick();
        ack_t = 1'b0;
        n_cmp++;
        if ({qi_t, pif_t.ack} !== 2'b11) begin
            n_err++;
            $display("FAIL err_exit: got qi/ack=%b want 11", {qi_t, pif_t.ack});
        end
        tick();
        n_cmp++;
        if (pif_t.ack !== 1'b0) begin
            n_err++;
            $display("FAIL err_exit_pulse: got ack=%b want 0", pif_t.ack);
        end
    endtask

    task automatic test_reset_accum();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pif.qsd = '1;
        tick();
        pif.qsd = '0;
        n_cmp++;
        if (qacc !== 1'b1) begin
            n_err++;
            $display("FAIL reach_accum: got qacc=%b want 1", qacc);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({qi, busy, pif.ack, red_exp, green_exp, blue_exp, threshold} !== {3'b100, 32'h0}) begin
            n_err++;
            $display("FAIL reset_mid_accum: got %h want %h", {qi, busy, pif.ack, red_exp, green_exp, blue_exp, threshold}, {3'b100, 32'h0});
        end
    endtask

    task automatic test_after_reset();
        set_sums(122, 265, 266, 133, 396, 198);
        thr_in = 8'h77; bgr_in = 8'h01; bgg_in = 8'h02; bgb_in = 8'h03;
        run_frame(2, 5, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            set_sums($urandom_range(0, 1200), $urandom_range(0, 1200), $urandom_range(0, 1200),
                     $urandom_range(0, 1200), $urandom_range(0, 1200), $urandom_range(0, 1200));
            thr_in = 8'($urandom_range(0, 255));
            bgr_in = 8'($urandom_range(0, 255));
            run_frame($urandom_range(0, 10), $urandom_range(0, 10), 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0; start_t = 1'b0; ack_t = 1'b0;
        thr_in = '0; bgr_in = '0; bgg_in = '0; bgb_in = '0;
        pif.qsd = '0; pif.qbgd = '0;
        set_sums(0, 0, 0, 0, 0, 0);
        pif_t.qsd = '0; pif_t.qbgd = '0;
        pif_t.red_sum = '0; pif_t.green_sum = '0; pif_t.blue_sum = '0;
        test_reset();
        test_basic();
        test_saturate();
        test_start_ignored();
        test_timeout();
        test_reset_accum();
        test_after_reset();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
